// File: rtl/multi_pulse_generator.sv
// Multi-channel programmable pulse/PWM generator.
// Each channel runs periodic, one-shot or burst waveforms with its own period and high time.

module mpg_channel #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [1:0]   mode,
  input  logic [N-1:0] ticks,
  input  logic [N-1:0] width,
  input  logic [N-1:0] burst,
  input  logic         start,
  output logic         out,
  output logic         busy,
  output logic         done
);
  // state | meaning
  // IDLE  | waiting for a launch; out/busy low
  // RUN   | counting cnt 0..T-1 through one or more periods
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_PER   = 2'd1;
  localparam logic [1:0] MODE_ONE   = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] t_q, t_d;
  logic [N-1:0] w_q, w_d;
  logic [N-1:0] b_q, b_d;
  logic [1:0]   m_q, m_d;
  logic         out_q, out_d;
  logic         done_q, done_d;
  logic         launch;
  logic         at_end;
  logic         live_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    w_d     = w_q;
    b_d     = b_q;
    m_d     = m_q;
    out_d   = out_q;
    done_d  = 1'b0;

    launch  = ena && (ticks != '0) &&
              ((mode == MODE_PER) ||
               (((mode == MODE_ONE) || (mode == MODE_BURST)) && start));
    at_end  = (cnt_q == (t_q - N'(1)));
    live_ok = (mode == MODE_PER) && (ticks != '0);

    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          out_d = 1'b0;
          if (launch) begin
            state_d = RUN;
            t_d     = ticks;
            w_d     = width;
            b_d     = (burst == '0) ? N'(1) : burst;
            m_d     = mode;
            out_d   = (width != '0);
          end
        end
        RUN: begin
          if (!at_end) begin
            cnt_d = cnt_q + N'(1);
            out_d = ((cnt_q + N'(1)) < w_q);
          end else begin
            cnt_d = '0;
            unique case (m_q)
              MODE_PER: begin
                // periodic channels pick up new period/width only at a boundary
                if (live_ok) begin
                  t_d   = ticks;
                  w_d   = width;
                  out_d = (width != '0);
                end else begin
                  state_d = IDLE;
                  out_d   = 1'b0;
                end
              end
              MODE_ONE: begin
                state_d = IDLE;
                out_d   = 1'b0;
                done_d  = 1'b1;
              end
              MODE_BURST: begin
                if (b_q == N'(1)) begin
                  state_d = IDLE;
                  out_d   = 1'b0;
                  done_d  = 1'b1;
                end else begin
                  b_d   = b_q - N'(1);
                  out_d = (w_q != '0);
                end
              end
              MODE_OFF: begin
                state_d = IDLE;
                out_d   = 1'b0;
              end
              default: begin
                state_d = IDLE;
                out_d   = 1'b0;
              end
            endcase
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      w_q     <= '0;
      b_q     <= '0;
      m_q     <= MODE_OFF;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      w_q     <= w_d;
      b_q     <= b_d;
      m_q     <= m_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
endmodule

module multi_pulse_generator #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   ena,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [N*CHANNELS-1:0] ticks,
  input  logic [N*CHANNELS-1:0] width,
  input  logic [N*CHANNELS-1:0] burst,
  input  logic [CHANNELS-1:0]   start,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   done
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mpg_channel #(.N(N)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena[i]),
      .mode  (mode[2*i +: 2]),
      .ticks (ticks[N*i +: N]),
      .width (width[N*i +: N]),
      .burst (burst[N*i +: N]),
      .start (start[i]),
      .out   (out[i]),
      .busy  (busy[i]),
      .done  (done[i])
    );
  end
endmodule

// File: tb/tb_multi_pulse_generator.sv
// Self-checking bench for multi_pulse_generator: vector table for one-shot/burst
// runs plus hand-written sequences for reset, periodic reload, retrigger and abort.

module tb_multi_pulse_generator;
  localparam int N = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [C-1:0]   ena, start;
  logic [2*C-1:0] mode;
  logic [N*C-1:0] ticks, width, burst;
  logic [C-1:0]   out, busy, done;

  multi_pulse_generator #(.N(N), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .ticks(ticks),
    .width(width), .burst(burst), .start(start),
    .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0] out;
    logic [C-1:0] busy;
    logic [C-1:0] done;
    string        name;
  } exp_t;

  typedef struct {
    int         ch;
    logic [1:0] mode;
    int         t;
    int         w;
    int         b;
    int         exp_hi;
    int         exp_periods;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [C-1:0] oh(input int ch, input bit v);
    logic [C-1:0] r;
    r = '0;
    r[ch] = v;
    return r;
  endfunction

  task automatic set_ch(input int ch, input bit e, input logic [1:0] m,
                        input int t, input int w, input int b, input bit s);
    ena[ch]           = e;
    mode[2*ch +: 2]   = m;
    ticks[N*ch +: N]  = N'(t);
    width[N*ch +: N]  = N'(w);
    burst[N*ch +: N]  = N'(b);
    start[ch]         = s;
  endtask

  task automatic clear_inputs();
    ena = '0; start = '0; mode = '0; ticks = '0; width = '0; burst = '0;
  endtask

  // push the expectation, advance one edge, then pop and compare
  task automatic cyc(input logic [C-1:0] eo, input logic [C-1:0] eb,
                     input logic [C-1:0] ed, input string name);
    exp_t e, g;
    e.out = eo; e.busy = eb; e.done = ed; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    vectors++;
    if (out !== g.out || busy !== g.busy || done !== g.done) begin
      miscompares++;
      $display("FAIL %s: got out=%b busy=%b done=%b, want out=%b busy=%b done=%b",
               g.name, out, busy, done, g.out, g.busy, g.done);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{ch:1, mode:2'd2, t:4, w:1, b:0, exp_hi:1, exp_periods:1, name:"oneshot t4 w1"};
    tbl[1] = '{ch:2, mode:2'd3, t:3, w:1, b:3, exp_hi:1, exp_periods:3, name:"burst t3 w1 b3"};
    tbl[2] = '{ch:2, mode:2'd3, t:3, w:1, b:0, exp_hi:1, exp_periods:1, name:"burst b0"};
    tbl[3] = '{ch:3, mode:2'd2, t:5, w:0, b:0, exp_hi:0, exp_periods:1, name:"oneshot w0"};
    tbl[4] = '{ch:3, mode:2'd2, t:3, w:7, b:0, exp_hi:3, exp_periods:1, name:"oneshot w>t"};
    tbl[5] = '{ch:0, mode:2'd3, t:1, w:1, b:2, exp_hi:1, exp_periods:2, name:"burst t1 b2"};
    tbl[6] = '{ch:1, mode:2'd3, t:2, w:1, b:4, exp_hi:1, exp_periods:4, name:"burst t2 b4"};

    // reset holds everything low even with launch conditions present
    rst = 1'b1;
    ena = '1; start = '0; mode = {C{2'b01}};
    ticks = {C{8'd5}}; width = {C{8'd2}}; burst = '0;
    cyc('0, '0, '0, "reset held 1");
    cyc('0, '0, '0, "reset held 2");
    rst = 1'b0;
    cyc('1, '1, '0, "first cycle after reset");
    cyc('1, '1, '0, "second cycle after reset");
    rst = 1'b1;
    cyc('0, '0, '0, "reset mid-run");
    rst = 1'b0;
    clear_inputs();
    cyc('0, '0, '0, "idle after reset");

    for (int v = 0; v < 7; v++) begin
      vec_t x;
      x = tbl[v];
      clear_inputs();
      set_ch(x.ch, 1'b1, x.mode, x.t, x.w, x.b, 1'b1);
      for (int k = 0; k < x.exp_periods * x.t; k++) begin
        cyc(oh(x.ch, (k % x.t) < x.exp_hi), oh(x.ch, 1'b1), '0, x.name);
        if (k == 0) begin
          // live changes after launch must not disturb latched values
          start[x.ch] = 1'b0;
          ticks[N*x.ch +: N] = N'(200);
          width[N*x.ch +: N] = N'(200);
          burst[N*x.ch +: N] = N'(50);
        end
      end
      cyc('0, '0, oh(x.ch, 1'b1), {x.name, " done"});
      cyc('0, '0, '0, {x.name, " after done"});
      clear_inputs();
    end

    // periodic ch0, period change takes effect at the boundary, then live mode off
    clear_inputs();
    set_ch(0, 1'b1, 2'd1, 5, 2, 0, 1'b0);
    for (int k = 0; k < 17; k++) begin
      bit eo;
      if (k == 2)  ticks[N*0 +: N] = N'(4);
      if (k == 14) mode[1:0] = 2'd0;
      eo = (k < 5) ? (k < 2) : (((k - 5) % 4) < 2);
      cyc(oh(0, eo), oh(0, 1'b1), '0, "periodic ch0");
    end
    cyc('0, '0, '0, "periodic stop no done");
    cyc('0, '0, '0, "periodic stays idle");

    // one-shot ch1 with start held through busy and final boundary
    clear_inputs();
    set_ch(1, 1'b1, 2'd2, 4, 1, 0, 1'b1);
    for (int k = 0; k < 4; k++)
      cyc(oh(1, k == 0), oh(1, 1'b1), '0, "oneshot retrigger ignored");
    cyc('0, '0, oh(1, 1'b1), "oneshot done");
    cyc(oh(1, 1'b1), oh(1, 1'b1), '0, "oneshot relaunch");
    ena[1] = 1'b0;
    cyc('0, '0, '0, "oneshot abort");

    // ch0 periodic, ch1 periodic w>t, ch2 burst aborted mid-run
    clear_inputs();
    set_ch(0, 1'b1, 2'd1, 5, 2, 0, 1'b0);
    set_ch(1, 1'b1, 2'd1, 5, 7, 0, 1'b0);
    set_ch(2, 1'b1, 2'd3, 3, 1, 5, 1'b1);
    for (int k = 0; k < 13; k++) begin
      logic [C-1:0] eo, eb;
      if (k == 1) start[2] = 1'b0;
      if (k == 4) ena[2] = 1'b0;
      eo = oh(0, (k % 5) < 2) | oh(1, 1'b1) | oh(2, (k < 4) && (k % 3 == 0));
      eb = oh(0, 1'b1) | oh(1, 1'b1) | oh(2, k < 4);
      cyc(eo, eb, '0, "abort/independence");
    end

    clear_inputs();
    cyc('0, '0, '0, "all disabled");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_pulse_generator.md
Name: multi_pulse_generator

Overview:
Multi-channel programmable pulse/PWM generator; each channel independently produces periodic, one-shot or burst waveforms with a programmable period and high time. It is the parametrised successor to the single-channel tick pulse generator and drives timing strobes, LED/PWM outputs and sample triggers across the design. All channels share one clock and reset.

Parameters:
N, 8, width of period, high-time and burst-count fields and of each channel counter
CHANNELS, 4, number of independent channels (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ena  input  CHANNELS  per-channel enable; low aborts/freezes channel
mode  input  2*CHANNELS  per-channel mode, ch i at [2i+1:2i]: 0 off, 1 periodic, 2 one-shot, 3 burst
ticks  input  N*CHANNELS  per-channel period in cycles, ch i at [N*i+N-1:N*i]
width  input  N*CHANNELS  per-channel high time in cycles
burst  input  N*CHANNELS  per-channel burst length in periods (mode 3)
start  input  CHANNELS  per-channel trigger for one-shot/burst
out  output  CHANNELS  registered waveform
busy  output  CHANNELS  channel in RUN state
done  output  CHANNELS  one-cycle strobe when one-shot/burst completes

Behaviour:
- Reset (rst=1 at posedge): all channels IDLE, counters 0, out=0, busy=0, done=0. rst overrides every other input.
- Per channel FSM: IDLE, RUN. Counter cnt runs 0..T-1, T = period.
- Launch from IDLE requires ena=1, ticks!=0, and either mode=1 (automatic, no start needed) or mode in {2,3} with start=1. mode=0 or ticks=0: no launch.
- On the launch edge: latch ticks, width, burst (burst=0 treated as 1), and mode into channel registers; state<=RUN, cnt<=0, busy<=1, out<=(width!=0). out and busy therefore rise together in the first cycle.
- Each RUN edge: if cnt==T-1 then period boundary, else cnt<=cnt+1 and out<=(cnt+1 < W).
- out is high for exactly min(W,T) cycles per period. W=0 means out is never high. W>=T means out is constantly high.
- Period boundary behaviour by latched mode:
  - Periodic: re-sample ticks/width (live inputs) and restart at cnt=0. If live mode!=1 or live ticks==0, go to IDLE with out<=0, busy<=0 and no done.
  - One-shot: go to IDLE, out<=0, busy<=0, done<=1 for one cycle.
  - Burst: decrement the remaining-period count. If it reaches 0, behave as one-shot completion; otherwise restart at cnt=0 with the latched values.
- Registers latched at launch are not affected by live ticks/width/burst/mode changes during one-shot/burst.
- ena=0 in any state: next edge state<=IDLE, cnt<=0, out<=0, busy<=0, done<=0 (abort, no done).
- start while busy=1 is ignored, including a start on the final-boundary edge. A new launch is possible from the cycle after busy falls.
- done is a single-cycle strobe and never coincides with busy=1.
- Counter arithmetic is N-bit unsigned with no wrap. Max period is 2^N-1 cycles.
- Channels are fully independent, and simultaneous events on different channels do not interact.

Test Plan:
- Reset: hold rst with ena=all 1, mode=1, ticks=5 -> out/busy/done all 0. First cycle after rst release: busy=1, out=1.
- Periodic PWM ch0: ticks=5, width=2, mode=1 -> out pattern 1,1,0,0,0 repeating. Change ticks to 4 mid-period -> new 1,1,0,0 pattern starts only after the current period ends.
- One-shot ch1: ticks=4, width=1, start pulse -> busy high 4 cycles, out high in cycle 1 only, done=1 in the cycle after busy falls. A second start during busy is ignored.
- Burst ch2: ticks=3, width=1, burst=3 -> exactly 3 out pulses spaced 3 cycles apart, then one done. burst=0 -> 1 pulse.
- Edge widths: width=0 -> out stays 0 while busy=1. width=7 with ticks=5 periodic -> out constant 1.
- Abort/independence: drop ena on ch2 mid-burst -> out=0, busy=0 next cycle, no done. ch0 periodic output is unchanged throughout. rst mid-run -> all channels IDLE next cycle.
